draw_sprite: RTL and testbench
==============================

# draw_sprite

Parametrised sprite overlay stage for the VGA pixel pipeline, the general successor of the fixed-position crate drawer. It overlays a SPRITE_W x SPRITE_H image, fetched from an external synchronous ROM, at a run-time position. It adds colour-key transparency, horizontal mirroring and multi-frame animation. It sits in the `vga_if` chain between background/earlier draw stages and later stages, and adds exactly two cycles of latency to every timing signal.

## Interface
Parameters:
- SPRITE_W, 64, sprite width in pixels; power of two
- SPRITE_H, 64, sprite height in pixels; power of two
- FRAMES, 4, animation frames stored back-to-back in ROM; ≥1, need not be a power of two
- FRAME_DIV, 8, video frames per animation step; ≥1
- TRANSP_EN, 1, enables colour-key transparency
- TRANSP_KEY, 12'hF0F, colour treated as transparent

Derived widths:
- XW = log2(SPRITE_W)
- YW = log2(SPRITE_H)
- FW = max(1, ceil(log2(FRAMES)))

Ports:
- clk60MHz  in  1  pixel clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- xpos  in  11  sprite left edge, in hcount units
- ypos  in  11  sprite top edge, in vcount units
- mirror  in  1  1 = horizontally flipped image
- anim_en  in  1  1 = animation advances
- rgb_pixel  in  12  ROM read data; valid one cycle after `pixel_addr`
- pixel_addr  out  FW+YW+XW  ROM address {frame, row, col}
- in  vga_if.in  —  upstream timing and rgb
- out  vga_if.out  —  downstream timing and rgb

## Operation
- **Shadow registers.** xpos_s, ypos_s and mirror_s load from the inputs on the rising edge of in.vblnk (in.vblnk = 1 while its previous sampled value was 0).
  - Input changes mid-frame never tear the image.
- **Animation.**
  - div_cnt (FRAME_DIV range) increments on each vblnk rising edge while anim_en = 1.
  - At FRAME_DIV-1, div_cnt wraps to 0 and frame_idx advances.
  - frame_idx wraps from FRAMES-1 to 0.
  - While anim_en = 0, both div_cnt and frame_idx hold.
  - When FRAMES = 1, frame_idx stays 0.
- **Address (combinational, cycle 0).**
  - dy = in.vcount - ypos_s, truncated to YW bits.
  - dx = in.hcount - xpos_s, truncated to XW bits.
  - col = mirror_s ? (SPRITE_W-1-dx) : dx.
  - pixel_addr = {frame_idx, dy, col}.
  - Out-of-window addresses are don't-care for the ROM; their data is discarded.
- **Stage 1.** Registers all in.* signals. Computes the window hit on the stage-1 counts using 12-bit arithmetic:
  - hit = !vblnk && !hblnk && h ≥ xpos_s && h < xpos_s+SPRITE_W && v ≥ ypos_s && v < ypos_s+SPRITE_H.
  - Using 12 bits means a sprite placed near 2047 never wraps to the left or top edge.
- **Stage 2.** Registers all stage-1 timing signals to out.*. The output colour is:
  - out.rgb = rgb_pixel when hit, unless TRANSP_EN and rgb_pixel == TRANSP_KEY.
  - Otherwise out.rgb = the stage-1 rgb.
- **Shadow timing.** Shadow values used for address and hit are those current at cycle 0 of the pixel. Shadow updates happen only during blanking, so no pixel sees mixed values.

## Timing
- Latency: in.* → out.* is exactly 2 cycles for vcount, hcount, vsync, hsync, vblnk, hblnk and rgb.
- ROM contract: synchronous read, 1 cycle. pixel_addr presented in cycle N gives rgb_pixel in cycle N+1, aligned with stage 1.
- Reset (rst_n = 0, asynchronous, any time including mid-line):
  - All out.* = 0.
  - Stage-1 registers, shadow registers, div_cnt and frame_idx = 0, and the vblnk edge detector = 0.
- pixel_addr is not registered. It follows in.* and the shadow registers in the same cycle; during reset it equals {0, in.vcount[YW-1:0], in.hcount[XW-1:0]}.
- First vblnk rising edge after reset release loads the shadows. Until then the sprite draws at (0,0), unmirrored, frame 0.
- Simultaneous events on one vblnk edge: position/mirror load and animation step occur together. Both take effect from the first visible pixel of the next frame.
- Changing anim_en mid-frame takes effect at the next vblnk edge only.

## Test plan
- **Reset mid-line.** Drive rst_n low while hcount = 300 → out.* = 0 within the same cycle. After release, out.hcount equals in.hcount delayed 2 cycles.
- **Placement.** Set xpos = 100, ypos = 50, with ROM data = address LSBs, and wait one vblnk edge.
  - out.rgb shows ROM data exactly for out.hcount 100..163 and out.vcount 50..113.
  - Background appears at hcount 99 and 164.
  - pixel_addr at in.hcount = 100, in.vcount = 50 is {0, 0, 0}.
- **Mirror and transparency.**
  - mirror = 1: at dx = 0, pixel_addr column = 63.
  - ROM returning 12'hF0F → background passes through.
  - With TRANSP_EN = 0, 12'hF0F is drawn.
- **Animation.** FRAMES = 3, FRAME_DIV = 2, anim_en = 1.
  - frame_idx sequence across vblnk edges: 0,1,1,2,2,0,0,1…
  - Dropping anim_en holds frame_idx and div_cnt.
- **No tearing and edge placement.**
  - Change xpos from 100 to 400 at vcount = 200 → the rest of the frame still draws at 100; the next frame draws at 400.
  - xpos = 1000 → only hcount 1000..1023 are drawn, with no wrap at hcount 0.

Source files
------------

// File: rtl/draw_sprite_if.sv
// vga_if: pixel-pipeline bundle of raster counts, sync/blank flags and colour.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_sprite.sv
// draw_sprite: ROM-backed sprite overlay with colour key, mirroring and animation;
// a two-stage vga_if pipeline stage.
module draw_sprite #(
    parameter int          SPRITE_W   = 64,
    parameter int          SPRITE_H   = 64,
    parameter int          FRAMES     = 4,
    parameter int          FRAME_DIV  = 8,
    parameter bit          TRANSP_EN  = 1'b1,
    parameter logic [11:0] TRANSP_KEY = 12'hF0F,
    localparam int         XW = $clog2(SPRITE_W),
    localparam int         YW = $clog2(SPRITE_H),
    localparam int         FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int         DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1
) (
    input  logic              clk60MHz,
    input  logic              rst_n,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    input  logic              mirror,
    input  logic              anim_en,
    input  logic [11:0]       rgb_pixel,
    output logic [FW+YW+XW-1:0] pixel_addr,
    vga_if.in                 in,
    vga_if.out                out
);
    logic [10:0]   xpos_s, ypos_s;
    logic          mirror_s, vblnk_prev;
    logic [DW-1:0] div_cnt;
    logic [FW-1:0] frame_idx;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic [11:0]   h12, v12;
    logic          hit0, hit1, key_hit;
    logic [10:0]   vcount1, hcount1;
    logic          vsync1, hsync1, vblnk1, hblnk1;
    logic [11:0]   rgb1;

    assign dx = XW'(in.hcount - xpos_s);
    assign dy = YW'(in.vcount - ypos_s);
    // SPRITE_W is a power of two, so W-1-dx is the bitwise complement
    assign pixel_addr = {frame_idx, dy, mirror_s ? ~dx : dx};

    // 12-bit compare keeps a sprite near 2047 from wrapping onto column/row 0
    assign h12  = {1'b0, in.hcount};
    assign v12  = {1'b0, in.vcount};
    assign hit0 = !in.vblnk && !in.hblnk &&
                  h12 >= {1'b0, xpos_s} && h12 < {1'b0, xpos_s} + 12'(SPRITE_W) &&
                  v12 >= {1'b0, ypos_s} && v12 < {1'b0, ypos_s} + 12'(SPRITE_H);
    assign key_hit = TRANSP_EN && (rgb_pixel == TRANSP_KEY);

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            xpos_s     <= '0;
            ypos_s     <= '0;
            mirror_s   <= 1'b0;
            vblnk_prev <= 1'b0;
            div_cnt    <= '0;
            frame_idx  <= '0;
        end else begin
            vblnk_prev <= in.vblnk;
            if (in.vblnk && !vblnk_prev) begin
                xpos_s   <= xpos;
                ypos_s   <= ypos;
                mirror_s <= mirror;
                if (anim_en) begin
                    div_cnt <= (div_cnt == DW'(FRAME_DIV - 1)) ? '0 : div_cnt + 1'b1;
                    if (div_cnt == DW'(FRAME_DIV - 1))
                        frame_idx <= (frame_idx == FW'(FRAMES - 1)) ? '0 : frame_idx + 1'b1;
                end
            end
        end
    end

    // hit is judged with the shadows current when the pixel's address was issued
    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            vcount1 <= '0;
            hcount1 <= '0;
            vsync1  <= 1'b0;
            hsync1  <= 1'b0;
            vblnk1  <= 1'b0;
            hblnk1  <= 1'b0;
            rgb1    <= '0;
            hit1    <= 1'b0;
        end else begin
            vcount1 <= in.vcount;
            hcount1 <= in.hcount;
            vsync1  <= in.vsync;
            hsync1  <= in.hsync;
            vblnk1  <= in.vblnk;
            hblnk1  <= in.hblnk;
            rgb1    <= in.rgb;
            hit1    <= hit0;
        end
    end

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            out.vcount <= '0;
            out.hcount <= '0;
            out.vsync  <= 1'b0;
            out.hsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.vcount <= vcount1;
            out.hcount <= hcount1;
            out.vsync  <= vsync1;
            out.hsync  <= hsync1;
            out.vblnk  <= vblnk1;
            out.hblnk  <= hblnk1;
            out.rgb    <= (hit1 && !key_hit) ? rgb_pixel : rgb1;
        end
    end
endmodule

// File: tb/tb_draw_sprite.sv
// tb_draw_sprite: two draw_sprite configurations against a behavioural raster model
// plus hand-computed placement, mirror, transparency and animation points.
module tb_draw_sprite;
    typedef struct packed {
        logic [10:0] v, h;
        logic        vs, hs, vb, hb;
        logic [11:0] rgb;
    } px_t;

    logic        clk60MHz = 1'b0;
    logic        rst_n = 1'b0, mirror = 1'b0, anim_en = 1'b0;
    logic [10:0] xpos = '0, ypos = '0;
    logic [11:0] pix_a, pix_b;
    logic [13:0] addr_a;
    logic [9:0]  addr_b;
    int          n_vec = 0, n_bad = 0;

    int  W[2]  = '{64, 32};
    int  H[2]  = '{64, 16};
    int  FR[2] = '{3, 1};
    int  DV[2] = '{2, 1};
    bit  TR[2] = '{1'b1, 1'b0};

    int  xs, ys, dvc[2], fr[2];
    bit  ms, pvb;
    px_t p1[2], p2[2];

    vga_if vin ();
    vga_if oa ();
    vga_if ob ();

    always #5 clk60MHz = ~clk60MHz;

    draw_sprite #(.FRAMES(3), .FRAME_DIV(2)) dut_a (
        .clk60MHz(clk60MHz), .rst_n(rst_n), .xpos(xpos), .ypos(ypos), .mirror(mirror),
        .anim_en(anim_en), .rgb_pixel(pix_a), .pixel_addr(addr_a), .in(vin), .out(oa));

    draw_sprite #(.SPRITE_W(32), .SPRITE_H(16), .FRAMES(1), .FRAME_DIV(1), .TRANSP_EN(1'b0)) dut_b (
        .clk60MHz(clk60MHz), .rst_n(rst_n), .xpos(xpos), .ypos(ypos), .mirror(mirror),
        .anim_en(anim_en), .rgb_pixel(pix_b), .pixel_addr(addr_b), .in(vin), .out(ob));

    function automatic logic [11:0] rom(int a);
        return (a % 16 == 5) ? 12'hF0F : {1'b0, 11'(a ^ (a >> 7))};
    endfunction

    always @(posedge clk60MHz) begin
        pix_a <= rom(int'(addr_a));
        pix_b <= rom(int'(addr_b));
    end

    function automatic int exp_addr(int d, int h, int v);
        int dx = (h - xs) & (W[d] - 1);
        int dy = (v - ys) & (H[d] - 1);
        int col = ms ? W[d] - 1 - dx : dx;
        return (fr[d] * H[d] + dy) * W[d] + col;
    endfunction

    function automatic px_t exp_px(int d, int h, int v, bit vs, bit hs, bit vb, bit hb, logic [11:0] bg);
        px_t p;
        logic [11:0] q = rom(exp_addr(d, h, v));
        bit hit = !vb && !hb && h >= xs && h < xs + W[d] && v >= ys && v < ys + H[d];
        p.v = 11'(v); p.h = 11'(h); p.vs = vs; p.hs = hs; p.vb = vb; p.hb = hb;
        p.rgb = (hit && !(TR[d] && q == 12'hF0F)) ? q : bg;
        return p;
    endfunction

    always @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            xs <= 0; ys <= 0; ms <= 0; pvb <= 0;
            for (int d = 0; d < 2; d++) begin
                dvc[d] <= 0; fr[d] <= 0; p1[d] <= '0; p2[d] <= '0;
            end
        end else begin
            pvb <= vin.vblnk;
            for (int d = 0; d < 2; d++) begin
                p1[d] <= exp_px(d, int'(vin.hcount), int'(vin.vcount), vin.vsync, vin.hsync,
                                vin.vblnk, vin.hblnk, vin.rgb);
                p2[d] <= p1[d];
            end
            if (vin.vblnk && !pvb) begin
                xs <= int'(xpos); ys <= int'(ypos); ms <= mirror;
                if (anim_en)
                    for (int d = 0; d < 2; d++) begin
                        dvc[d] <= (dvc[d] + 1) % DV[d];
                        if (dvc[d] + 1 == DV[d]) fr[d] <= (fr[d] + 1) % FR[d];
                    end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk60MHz) begin
        chk("a_rgb", 32'(oa.rgb), 32'(p2[0].rgb));
        chk("a_timing", 32'({oa.vcount, oa.hcount, oa.vsync, oa.hsync, oa.vblnk, oa.hblnk}),
            32'({p2[0].v, p2[0].h, p2[0].vs, p2[0].hs, p2[0].vb, p2[0].hb}));
        chk("b_rgb", 32'(ob.rgb), 32'(p2[1].rgb));
        chk("b_timing", 32'({ob.vcount, ob.hcount, ob.vsync, ob.hsync, ob.vblnk, ob.hblnk}),
            32'({p2[1].v, p2[1].h, p2[1].vs, p2[1].hs, p2[1].vb, p2[1].hb}));
        chk("a_addr", 32'(addr_a), 32'(exp_addr(0, int'(vin.hcount), int'(vin.vcount))));
        chk("b_addr", 32'(addr_b), 32'(exp_addr(1, int'(vin.hcount), int'(vin.vcount))));
    end

    task automatic drive(int v, int h, bit vb, bit hb, logic [11:0] rgb);
        @(posedge clk60MHz);
        #1;
        vin.vcount = 11'(v); vin.hcount = 11'(h); vin.vblnk = vb; vin.hblnk = hb;
        vin.rgb = rgb; vin.vsync = 1'($urandom); vin.hsync = 1'($urandom);
    endtask

    task automatic vpulse();
        drive(768, 0, 1'b1, 1'b1, 12'h000);
        drive(769, 0, 1'b1, 1'b1, 12'h000);
    endtask

    function automatic logic [10:0] pick_pos();
        int sel = $urandom_range(0, 6);
        return (sel == 0) ? 11'd0 : (sel == 1) ? 11'd100 : (sel == 2) ? 11'd400 :
               (sel == 3) ? 11'd1000 : (sel == 4) ? 11'd2030 : (sel == 5) ? 11'd2040 :
               11'($urandom);
    endfunction

    task automatic rand_frame();
        if ($urandom_range(0, 1) == 1) begin
            xpos = pick_pos(); ypos = pick_pos(); mirror = 1'($urandom);
        end
        anim_en = ($urandom_range(0, 3) != 0);
        vpulse();
        for (int l = 0; l < 10; l++) begin
            int v = (ys - 3 + $urandom_range(0, 70)) & 2047;
            if (l == 5) begin
                // changed mid-frame; must not affect this frame
                xpos = pick_pos(); ypos = pick_pos(); mirror = 1'($urandom);
                anim_en = 1'($urandom);
            end
            for (int i = 0; i < 76; i++)
                drive(v, (xs - 4 + i) & 2047, 1'b0, $urandom_range(0, 15) == 0, 12'($urandom));
            drive(v, 1100, 1'b0, 1'b1, 12'h000);
            drive(v, 1101, 1'b0, 1'b1, 12'h000);
        end
    endtask

    int          seq[8]   = '{0, 1, 1, 2, 2, 0, 0, 1};
    int          sv[6]    = '{51, 51, 51, 50, 113, 50};
    int          sh[6]    = '{99, 101, 164, 105, 163, 100};
    logic [11:0] sbg[6]   = '{12'hABC, 12'h123, 12'h456, 12'h789, 12'h321, 12'hAAA};
    int          saddr[6] = '{127, 65, 64, 5, 4095, 0};
    logic [11:0] sa[6]    = '{12'hABC, 12'h041, 12'h456, 12'h789, 12'h7E0, 12'h000};
    logic [11:0] sb[6]    = '{12'hABC, 12'h021, 12'h456, 12'hF0F, 12'h321, 12'h000};

    initial begin
        vin.vcount = '0; vin.hcount = '0; vin.vsync = 1'b0; vin.hsync = 1'b0;
        vin.vblnk = 1'b0; vin.hblnk = 1'b0; vin.rgb = '0;
        for (int i = 0; i < 3; i++) drive(10, 20 + i, 1'b0, 1'b0, 12'hFFF);
        chk("reset_out_rgb", 32'(oa.rgb), 32'h0);
        chk("reset_out_hcount", 32'(oa.hcount), 32'h0);
        rst_n = 1'b1;

        xpos = 11'd100; ypos = 11'd50; mirror = 1'b0; anim_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            vpulse();
            drive(51, 101, 1'b0, 1'b0, 12'h000);
            #1 chk("frame_seq", 32'(addr_a[13:12]), 32'(seq[f]));
            if (f == 0)
                for (int i = 0; i < 8; i++) begin
                    if (i < 6) drive(sv[i], sh[i], 1'b0, 1'b0, sbg[i]);
                    else drive(60, 0, 1'b0, 1'b1, 12'h000);
                    #1;
                    if (i < 6) chk("place_addr", 32'(addr_a), 32'(saddr[i]));
                    if (i >= 2) begin
                        chk("place_a_rgb", 32'(oa.rgb), 32'(sa[i - 2]));
                        chk("place_b_rgb", 32'(ob.rgb), 32'(sb[i - 2]));
                    end
                end
        end
        anim_en = 1'b0;
        for (int f = 0; f < 3; f++) begin
            vpulse();
            drive(51, 101, 1'b0, 1'b0, 12'h000);
            #1 chk("anim_hold", 32'(addr_a[13:12]), 32'd1);
        end
        anim_en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            vpulse();
            drive(51, 101, 1'b0, 1'b0, 12'h000);
            #1 chk("anim_resume", 32'(addr_a[13:12]), 32'(f + 1));
        end

        mirror = 1'b1;
        vpulse();
        drive(50, 100, 1'b0, 1'b0, 12'h000);
        #1 chk("mirror_a_col", 32'(addr_a[5:0]), 32'd63);
        chk("mirror_b_col", 32'(addr_b[4:0]), 32'd31);

        for (int f = 0; f < 20; f++) rand_frame();

        drive(60, 300, 1'b0, 1'b0, 12'h5A5);
        #2 rst_n = 1'b0;
        #1 chk("midline_rst_a", 32'({oa.vcount, oa.hcount, oa.vsync, oa.hsync, oa.vblnk, oa.hblnk}), 32'h0);
        chk("midline_rst_b_rgb", 32'(ob.rgb), 32'h0);
        chk("midline_rst_addr", 32'(addr_a), 32'({2'b00, 6'd60, 6'(300)}));
        drive(60, 301, 1'b0, 1'b0, 12'h5A5);
        drive(60, 302, 1'b0, 1'b0, 12'h5A5);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) drive(60, 303 + i, 1'b0, 1'b0, 12'($urandom));

        for (int f = 0; f < 12; f++) rand_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
